// File: rtl/spi_burst_controller_pkg.sv
// Shared types and field positions for the SPI burst controller.
package spi_burst_controller_pkg;

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_ADDR  = 6'b000010,
    S_WDATA = 6'b000100,
    S_RDATA = 6'b001000,
    S_RWAIT = 6'b010000,
    S_DONE  = 6'b100000
  } state_t;

  localparam int RX_WR = 0;
  localparam int RX_RD = 1;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_COLL = 2;
  localparam int ST_TMO  = 3;
  localparam int ST_OVR  = 4;

  localparam int ADDR_LEN_LSB = 8;
  localparam int ADDR_SEL_LSB = 16;

  localparam int WR_MAX = 4;

  function automatic logic [4:0] clamp_len(
    input logic [7:0]  len,
    input int unsigned cap
  );
    if (len == 8'd0) return 5'd1;
    if (32'(len) > cap) return 5'(cap);
    return 5'(len);
  endfunction

endpackage

// File: rtl/spi_burst_controller_bit_reverse8.sv
// Byte bit-order swap used on the tx and rx byte paths.
module bit_reverse8 (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  assign dout = {<<{din}};
endmodule

// File: rtl/spi_burst_controller.sv
// Register-access burst sequencer in front of a byte-wide SPI engine.
module spi_burst_controller
  import spi_burst_controller_pkg::*;
#(
  parameter int ADDR_W    = 7,
  parameter int MAX_BURST = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter int TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PC_rx,
  input  logic [31:0] PC_addr,
  input  logic [31:0] PC_val,
  output logic [31:0] PC_tx,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [7:0]  byte_out,
  output logic        byte_rd,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        cs_hold
);

  state_t            state;
  logic [1:0]        rx_s1;
  logic [1:0]        rx_s2;
  logic [1:0]        rise;
  logic              is_read;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       val_q;
  logic [4:0]        len_q;
  logic [4:0]        idx_q;
  logic [4:0]        idx_nx;
  logic              last;
  logic [15:0]       cnt_q;
  logic [2:0]        err_q;
  logic [7:0]        out_raw;
  logic [7:0]        out_rev;
  logic [7:0]        rx_rev;
  logic [7:0]        rx_byte;
  logic [7:0]        rbuf [MAX_BURST];
  logic [7:0]        rd_lo;
  logic [7:0]        rd_hi;
  logic [15:0]       rd_q;
  logic [3:0]        sel;
  logic [7:0]        status;
  logic              hs;
  logic              active;
  logic              tmo_hit;
  logic              unused_bits;

  assign unused_bits = ^{PC_rx[31:2], PC_addr[31:20], PC_addr[7]};

  bit_reverse8 u_rev_tx (.din(out_raw), .dout(out_rev));
  bit_reverse8 u_rev_rx (.din(rx_data), .dout(rx_rev));

  assign byte_out = LSB_FIRST ? out_rev : out_raw;
  assign rx_byte  = LSB_FIRST ? rx_rev : rx_data;

  assign rise    = rx_s1 & ~rx_s2;
  assign hs      = byte_valid & byte_ready;
  assign idx_nx  = idx_q + 5'd1;
  assign last    = (idx_q == len_q - 5'd1);
  assign active  = (state != S_IDLE) && (state != S_DONE);
  assign tmo_hit = active && !hs && !rx_valid &&
                   (cnt_q >= 16'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1      <= '0;
      rx_s2      <= '0;
      state      <= S_IDLE;
      is_read    <= 1'b0;
      addr_q     <= '0;
      val_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      err_q      <= '0;
      out_raw    <= '0;
      byte_valid <= 1'b0;
      byte_rd    <= 1'b0;
      cs_hold    <= 1'b0;
    end else begin
      rx_s1 <= PC_rx[1:0];
      rx_s2 <= rx_s1;
      cnt_q <= (!active || hs || rx_valid) ? 16'd0 : cnt_q + 16'd1;
      if (tmo_hit) begin
        err_q[1]   <= 1'b1;
        state      <= S_DONE;
        byte_valid <= 1'b0;
        byte_rd    <= 1'b0;
        cs_hold    <= 1'b0;
        out_raw    <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (rise == 2'b11) begin
              err_q[0] <= 1'b1;
            end else if (rise != 2'b00) begin
              is_read    <= rise[RX_RD];
              addr_q     <= PC_addr[ADDR_W-1:0];
              val_q      <= PC_val;
              len_q      <= clamp_len(
                PC_addr[ADDR_LEN_LSB +: 8],
                rise[RX_RD] ? 32'(MAX_BURST) : 32'(WR_MAX));
              idx_q      <= '0;
              err_q      <= '0;
              state      <= S_ADDR;
              out_raw    <= {~rise[RX_RD], PC_addr[ADDR_W-1:0]};
              byte_valid <= 1'b1;
              byte_rd    <= 1'b0;
              cs_hold    <= 1'b1;
            end
          end
          S_ADDR: begin
            if (hs) begin
              if (is_read) begin
                state   <= S_RDATA;
                out_raw <= 8'h00;
                byte_rd <= 1'b1;
              end else begin
                state   <= S_WDATA;
                out_raw <= val_q[7:0];
              end
            end
          end
          S_WDATA: begin
            if (hs) begin
              if (last) begin
                state      <= S_DONE;
                byte_valid <= 1'b0;
                cs_hold    <= 1'b0;
                out_raw    <= '0;
              end else begin
                idx_q   <= idx_nx;
                out_raw <= val_q[{idx_nx[1:0], 3'b000} +: 8];
              end
            end
          end
          S_RDATA: begin
            if (hs) begin
              state      <= S_RWAIT;
              byte_valid <= 1'b0;
              byte_rd    <= 1'b0;
            end
          end
          S_RWAIT: begin
            if (rx_valid) begin
              if (last) begin
                state   <= S_DONE;
                cs_hold <= 1'b0;
              end else begin
                idx_q      <= idx_nx;
                state      <= S_RDATA;
                byte_valid <= 1'b1;
                byte_rd    <= 1'b1;
              end
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
      // late write so an overrun in the trigger cycle survives the clear
      if (rx_valid && state != S_RWAIT) err_q[2] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_BURST; i++) rbuf[i] <= '0;
    end else if (state == S_RWAIT && rx_valid) begin
      for (int i = 0; i < MAX_BURST; i++)
        if (idx_q == 5'(i)) rbuf[i] <= rx_byte;
    end
  end

  assign sel = PC_addr[ADDR_SEL_LSB +: 4];

  always_comb begin
    rd_lo = '0;
    rd_hi = '0;
    for (int i = 0; i < MAX_BURST; i++) begin
      if (5'(i) == {sel, 1'b0}) rd_lo = rbuf[i];
      if (5'(i) == {sel, 1'b1}) rd_hi = rbuf[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_q <= '0;
    else        rd_q <= {rd_hi, rd_lo};
  end

  always_comb begin
    status          = '0;
    status[ST_BUSY] = (state != S_IDLE);
    status[ST_DONE] = (state == S_DONE);
    status[ST_COLL] = err_q[0];
    status[ST_TMO]  = err_q[1];
    status[ST_OVR]  = err_q[2];
  end

  assign PC_tx = {status, 8'h00, rd_q};

endmodule

// File: tb/tb_spi_burst_controller.sv
// Bench: MSB-first and LSB-first instances on shared stimulus vs a transaction model.
module tb_spi_burst_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PC_rx, PC_addr, PC_val;
  logic        byte_ready, rx_valid;
  logic [7:0]  rx_data;
  logic [31:0] tx0, tx1;
  logic        bv0, bv1, brd0, brd1, cs0, cs1;
  logic [7:0]  bo0, bo1;

  int checks = 0;
  int errors = 0;
  logic [7:0] mbuf [32];

  always #5 clk = ~clk;

  spi_burst_controller #(
    .ADDR_W(7), .MAX_BURST(8), .LSB_FIRST(1'b0), .TIMEOUT(16)
  ) d0 (
    .clk(clk), .rst_n(rst_n), .PC_rx(PC_rx), .PC_addr(PC_addr),
    .PC_val(PC_val), .PC_tx(tx0), .byte_valid(bv0),
    .byte_ready(byte_ready), .byte_out(bo0), .byte_rd(brd0),
    .rx_valid(rx_valid), .rx_data(rx_data), .cs_hold(cs0)
  );

  spi_burst_controller #(
    .ADDR_W(7), .MAX_BURST(8), .LSB_FIRST(1'b1), .TIMEOUT(16)
  ) d1 (
    .clk(clk), .rst_n(rst_n), .PC_rx(PC_rx), .PC_addr(PC_addr),
    .PC_val(PC_val), .PC_tx(tx1), .byte_valid(bv1),
    .byte_ready(byte_ready), .byte_out(bo1), .byte_rd(brd1),
    .rx_valid(rx_valid), .rx_data(rx_data), .cs_hold(cs1)
  );

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] val;
    logic [23:0] rxd;
    int          nhs;
    bit          rbchk;
    logic [15:0] rb0;
    logic [15:0] rb1;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rv(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic int eff_len(input bit rd, input int len);
    int cap;
    cap = rd ? 8 : 4;
    if (len == 0) return 1;
    return (len > cap) ? cap : len;
  endfunction

  task automatic all_zero(input string name);
    chk(name, {tx0, tx1},
        64'h0);
    chk({name, "_pins"},
        {40'h0, bv0, bv1, brd0, brd1, cs0, cs1, 2'b00, bo0, bo1},
        64'h0);
  endtask

  task automatic idle_gap();
    PC_rx = 32'h0;
    byte_ready = 1'b0;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_txn(input bit rd, input logic [31:0] addr,
                         input logic [31:0] val, input logic [23:0] rxd,
                         input int pready, input int exp_n);
    logic [7:0] q[$];
    bit         qrd[$];
    int n, nq, hs_cnt, dones, pend, slot, cyc;
    bit seen_done, prev_stall, busy, done;
    logic [7:0] prev_b, rb;
    n = eff_len(rd, int'(addr[15:8]));
    q.push_back({~rd, addr[6:0]});
    qrd.push_back(1'b0);
    for (int k = 0; k < n; k++) begin
      q.push_back(rd ? 8'h00 : val[8*k +: 8]);
      qrd.push_back(rd);
    end
    nq = q.size();
    hs_cnt = 0; dones = 0; pend = -1; slot = 0;
    seen_done = 0; prev_stall = 0; prev_b = '0;
    PC_addr = addr;
    PC_val = val;
    PC_rx = rd ? 32'h2 : 32'h1;
    for (cyc = 0; cyc < 400; cyc++) begin
      rx_valid = 1'b0;
      if (pend == 0) begin
        rb = (rxd != 0 && slot < 3) ? rxd[8*slot +: 8] : 8'($urandom);
        rx_valid = 1'b1;
        rx_data = rb;
        mbuf[slot] = rb;
        slot++;
        pend = -1;
      end else if (pend > 0) begin
        pend--;
      end
      busy = tx0[0+24];
      done = tx0[1+24];
      if (done) begin
        dones++;
        seen_done = 1;
      end
      chk("cs_hold", {cs0, cs1}, {2{busy && !done}});
      if (seen_done && !busy) break;
      if (prev_stall && bv0) chk("stable", bo0, prev_b);
      byte_ready = ($urandom_range(99) < pready);
      chk("valid_pair", bv1, bv0);
      if (bv0 && byte_ready) begin
        if (q.size() == 0) begin
          chk("extra_byte", {bo0, 8'h00}, 16'hFFFF);
        end else begin
          chk("byte", {bo0, bo1, 7'b0, brd0, 7'b0, brd1},
              {q[0], rv(q[0]), 7'b0, qrd[0], 7'b0, qrd[0]});
          if (qrd[0]) pend = $urandom_range(2);
          void'(q.pop_front());
          void'(qrd.pop_front());
        end
        hs_cnt++;
      end
      prev_stall = bv0 && !byte_ready;
      prev_b = bo0;
      @(negedge clk);
    end
    if (cyc >= 400) chk("txn_timeout", cyc, 0);
    chk("handshakes", hs_cnt, nq);
    if (exp_n >= 0) chk("handshakes_tbl", hs_cnt, exp_n);
    chk("done_pulses", dones, 1);
    chk("status_clean", {tx0[31:24], tx1[31:24]}, 16'h0);
    idle_gap();
  endtask

  task automatic readback();
    logic [7:0] lo, hi;
    for (int s = 0; s < 10; s++) begin
      PC_addr = 32'(s) << 16;
      @(negedge clk);
      lo = (2*s < 8) ? mbuf[2*s] : 8'h00;
      hi = (2*s+1 < 8) ? mbuf[2*s+1] : 8'h00;
      chk($sformatf("rb_sel%0d", s), {tx0[15:0], tx1[15:0]},
          {hi, lo, rv(hi), rv(lo)});
    end
  endtask

  initial begin
    vec_t tbl[6];
    int   vcount, cyc;
    bit   saw;
    tbl[0] = '{1, 32'h0311, 32'h0, 24'hC3B2A1, 4, 1, 16'hB2A1, 16'h00C3};
    tbl[1] = '{0, 32'h0205, 32'h0000BEEF, 24'h0, 3, 0, 16'h0, 16'h0};
    tbl[2] = '{0, 32'h0001, 32'h00000001, 24'h0, 2, 0, 16'h0, 16'h0};
    tbl[3] = '{0, 32'h0900, 32'h44332211, 24'h0, 5, 0, 16'h0, 16'h0};
    tbl[4] = '{1, 32'h0000, 32'h0, 24'h0, 2, 0, 16'h0, 16'h0};
    tbl[5] = '{1, 32'h147F, 32'h0, 24'h0, 9, 0, 16'h0, 16'h0};
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h00;

    rst_n = 1'b0;
    PC_rx = '0; PC_addr = '0; PC_val = '0;
    byte_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (3) @(negedge clk);
    all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (tbl[i]) begin
      run_txn(tbl[i].rd, tbl[i].addr, tbl[i].val, tbl[i].rxd,
              100, tbl[i].nhs);
      if (tbl[i].rbchk) begin
        PC_addr = 32'h0;
        @(negedge clk);
        chk("tbl_sel0", tx0[15:0], tbl[i].rb0);
        PC_addr = 32'h1_0000;
        @(negedge clk);
        chk("tbl_sel1", tx0[15:0], tbl[i].rb1);
      end
      readback();
    end

    // collision: both trigger bits rise together
    PC_addr = 32'h0105;
    PC_rx = 32'h3;
    saw = 0;
    repeat (6) begin
      @(negedge clk);
      saw |= bv0 | bv1;
    end
    chk("coll_novalid", saw, 1'b0);
    chk("coll_status", {tx0[31:24], tx1[31:24]}, 16'h0404);
    idle_gap();
    run_txn(0, 32'h0105, 32'h5A, 24'h0, 100, 2);

    // overrun: stray rx strobe while idle
    rx_valid = 1'b1;
    rx_data = 8'h77;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    chk("ovr_status", {tx0[31:24], tx1[31:24]}, 16'h1010);
    run_txn(1, 32'h0222, 32'h0, 24'h0, 100, 3);
    readback();

    // stall beyond the timeout
    PC_addr = 32'h0103;
    PC_val = 32'hAA;
    PC_rx = 32'h1;
    byte_ready = 1'b0;
    vcount = 0;
    for (cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (bv0) vcount++;
      if (tx0[27]) break;
    end
    chk("tmo_seen", cyc < 100, 1'b1);
    chk("tmo_valid_cycles", vcount, 16);
    @(negedge clk);
    chk("tmo_idle", {tx0[31:24], tx1[31:24], 6'b0, cs0, cs1},
        {8'h08, 8'h08, 8'h00});
    idle_gap();
    readback();

    // reset while waiting for receive data
    PC_addr = 32'h0344;
    PC_rx = 32'h2;
    byte_ready = 1'b1;
    saw = 0;
    for (cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      if (bv0 && brd0) begin
        saw = 1;
        break;
      end
    end
    chk("reach_rdata", saw, 1'b1);
    @(negedge clk);
    chk("in_rwait", {bv0, tx0[24], cs0}, 3'b011);
    rst_n = 1'b0;
    #1;
    all_zero("mid_reset");
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h00;
    @(negedge clk);
    all_zero("held_reset");
    rst_n = 1'b1;
    idle_gap();
    run_txn(1, 32'h0344, 32'h0, 24'h0, 100, 4);
    readback();

    // randomized transactions
    for (int r = 0; r < 25; r++) begin
      logic [31:0] a;
      a = (32'($urandom_range(20)) << 8) | 32'($urandom_range(127));
      run_txn(1'($urandom), a, $urandom, 24'h0,
              int'($urandom_range(60, 100)), -1);
      readback();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_burst_controller.md
SPI_BURST_CONTROLLER -- requirements
Module: spi_burst_controller

Interface
REQ-001 Parameter ADDR_W, default 7: register address width; ADDR_W+1 SHALL equal 8.
REQ-002 Parameter MAX_BURST, default 8: maximum bytes per read burst, range 1..16.
REQ-003 Parameter LSB_FIRST, default 1: 1 means every byte is bit-reversed toward and from the byte engine.
REQ-004 Parameter TIMEOUT, default 1024: maximum cycles the block waits on any single engine handshake.
REQ-005 Port clk, in, 1: single clock; all logic on its rising edge.
REQ-006 Port rst_n, in, 1: asynchronous, active-low reset.
REQ-007 Port PC_rx, in, 32: PC trigger word; bit0 starts a write, bit1 starts a read, edge-detected.
REQ-008 Port PC_addr, in, 32: [ADDR_W-1:0] register address; [15:8] burst length LEN; [19:16] read-buffer select.
REQ-009 Port PC_val, in, 32: write data; byte k goes out as burst byte k.
REQ-010 Port PC_tx, out, 32: {status[7:0], 0[7:0], sel_byte1, sel_byte0}.
REQ-011 Port byte_valid, out, 1: a byte is offered to the engine.
REQ-012 Port byte_ready, in, 1: the engine accepts the offered byte.
REQ-013 Port byte_out, out, 8: byte to shift out.
REQ-014 Port byte_rd, out, 1: the engine must return the received byte for this slot.
REQ-015 Port rx_valid, in, 1: one-cycle strobe marking rx_data valid.
REQ-016 Port rx_data, in, 8: byte received by the engine.
REQ-017 Port cs_hold, out, 1: keeps chip-select asserted for the whole transaction.

Function
REQ-018 PC_rx SHALL pass through two registers; a trigger is a 0->1 change between stage2 and stage1.
REQ-019 A write trigger and a read trigger in the same cycle SHALL start nothing and SHALL set status[2] (collision).
REQ-020 Triggers arriving outside IDLE SHALL be ignored.
REQ-021 LEN SHALL be sampled at the trigger: 0 becomes 1; for a write, values above 4 clamp to 4; for a read, values above MAX_BURST clamp to MAX_BURST.
REQ-022 States SHALL be IDLE, ADDR, WDATA, RDATA, RWAIT, DONE.
- IDLE -> ADDR on a valid trigger.
- ADDR -> WDATA on a write, or -> RDATA on a read, once the address byte is handed over.
- WDATA -> DONE after LEN bytes.
- RDATA -> RWAIT after each dummy byte is accepted.
- RWAIT -> RDATA on rx_valid while bytes remain, otherwise -> DONE.
- DONE -> IDLE after one cycle.
REQ-023 ADDR SHALL offer {~is_read, addr[ADDR_W-1:0]} with byte_rd=0.
REQ-024 WDATA SHALL offer PC_val[8k+7:8k] for k=0..LEN-1, with PC_val sampled at the trigger.
REQ-025 RDATA SHALL offer 0x00 with byte_rd=1.
REQ-026 The rx byte of each read slot SHALL be stored at buf[k].
REQ-027 A byte transfer SHALL complete in the cycle where byte_valid and byte_ready are both 1; byte_out SHALL stay stable while valid and not ready.
REQ-028 When LSB_FIRST=1, byte_out and the stored rx bytes SHALL be bit-reversed, combinationally with no added latency.
REQ-029 cs_hold SHALL be 1 from ADDR entry through the last handshake, and 0 in DONE and IDLE.
REQ-030 A 16-bit cycle counter SHALL clear on every handshake or rx_valid.
- Reaching TIMEOUT SHALL set status[3], abort to DONE, and leave the buffer partial.
REQ-031 rx_valid outside RWAIT SHALL be dropped and SHALL set status[4] (overrun).
REQ-032 status[0] SHALL be 1 when not in IDLE (busy).
REQ-033 status[1] SHALL pulse to 1 for exactly one cycle in DONE.
REQ-034 status[7:5] SHALL be 0.
REQ-035 Error bits status[4:2] SHALL be sticky until the next accepted trigger.
REQ-036 PC_tx[15:0] SHALL return buf[2*sel+1], buf[2*sel], registered with one-cycle latency.
- A select past MAX_BURST SHALL read 0x00.
REQ-037 Minimum write transaction: 1 cycle (ADDR entry) plus (LEN+1) handshakes plus 1 cycle (DONE).

Reset
REQ-038 Asserting rst_n low SHALL immediately force:
- state IDLE;
- byte_valid=0, byte_rd=0, cs_hold=0, byte_out=0x00, PC_tx=0;
- sync stages, counters, status and buffer all 0.
REQ-039 Reset mid-transaction SHALL abandon it without any further handshake; deassertion SHALL be synchronised by the parent.

Structure
REQ-040 A shared package SHALL hold the state encoding (one-hot), the PC_rx bit indices, the status bit indices and the PC_addr field offsets.
REQ-041 Bit reversal SHALL be a sub-module, bit_reverse8, instantiated twice.
REQ-042 The read buffer SHALL be a flop array, not a RAM.

Verification
REQ-043 Write: PC_addr=0x0205, PC_val=0x0000BEEF, PC_rx bit0 0->1, byte_ready held 1, LSB_FIRST=0.
- Bytes offered SHALL be 0x85, 0xEF, 0xBE.
- cs_hold SHALL be high throughout; the done pulse occurs once.
REQ-044 Read: LEN=3, addr 0x11, the engine returns 0xA1, 0xB2, 0xC3.
- The address byte SHALL be 0x11.
- Select 0 SHALL give PC_tx[15:0]=0xB2A1; select 1 SHALL give 0x00C3.
REQ-045 LSB_FIRST=1 write of addr 0x01, LEN=1, data 0x01: byte_out SHALL be 0x81 then 0x80.
REQ-046 Stall: byte_ready held low beyond TIMEOUT=16.
- status[3] SHALL set, the block SHALL return to IDLE, and cs_hold SHALL drop.
REQ-047 Bits 0 and 1 of PC_rx rise together: no byte_valid SHALL occur and status[2]=1.
- Status SHALL clear on the next valid trigger.
REQ-048 rst_n pulsed low in RWAIT: all outputs SHALL be 0 within the same cycle.
- A subsequent read SHALL complete normally.
